// File: rtl/cam_pkg.sv
// Shared types and default sizes for the camera line-buffer readout scheduler.
//   cam_state_e : readout sequencer states
//   cam_beat_t  : one stream byte plus its frame/line markers
package cam_pkg;

  localparam int unsigned CAM_ADDR_W   = 11;
  localparam int unsigned CAM_HALF_LEN = 780;
  localparam int unsigned CAM_LINE_W   = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    ACTIVE  = 2'd2,
    FLUSH   = 2'd3
  } cam_state_e;

  typedef struct packed {
    logic       eol;
    logic       sof;
    logic [7:0] data;
  } cam_beat_t;

endpackage

// File: rtl/cam_readout_sched_if.sv
// RAM read port plus outgoing byte stream of the readout scheduler.
//   master : scheduler side (drives rd_en/rd_addr and the out_* stream)
//   slave  : RAM + stream consumer side (drives rd_data and out_ready)
interface cam_readout_sched_if
  import cam_pkg::*;
#(
  parameter int unsigned ADDR_W = CAM_ADDR_W
);

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_sof;
  logic              out_eol;

  modport master (
    output rd_en, rd_addr, out_data, out_valid, out_sof, out_eol,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, out_data, out_valid, out_sof, out_eol,
    output rd_data, out_ready
  );

endinterface

// File: rtl/cam_skid_fifo.sv
// Two-entry FIFO holding {eol,sof,data}. The head entry is a register so the
// stream outputs come straight from flops.
//   pclk, rst_n : clock, async active-low reset
//   push, din   : write one beat (caller guarantees space)
//   pop         : consume head beat (only while head_vld)
//   head        : oldest beat, cleared when the FIFO empties
//   head_vld    : FIFO not empty
//   count       : occupancy 0..2
module cam_skid_fifo
  import cam_pkg::*;
(
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       push,
  input  cam_beat_t  din,
  input  logic       pop,
  output cam_beat_t  head,
  output logic       head_vld,
  output logic [1:0] count
);

  cam_beat_t  tail;
  cam_beat_t  head_n;
  cam_beat_t  tail_n;
  logic [1:0] count_n;

  // Next-state of the head/tail pair for each push/pop combination.
  always_comb begin
    head_n  = head;
    tail_n  = tail;
    count_n = count;
    unique case ({push, pop})
      2'b10: begin
        if (count == 2'd0) head_n = din;
        else               tail_n = din;
        count_n = count + 2'd1;
      end
      2'b01: begin
        head_n  = (count == 2'd2) ? tail : cam_beat_t'('0);
        count_n = count - 2'd1;
      end
      2'b11: begin
        if (count == 2'd2) begin
          head_n = tail;
          tail_n = din;
        end else begin
          head_n = din;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      head_vld <= 1'b0;
    end else begin
      head     <= head_n;
      tail     <= tail_n;
      count    <= count_n;
      head_vld <= (count_n != 2'd0);
    end
  end

endmodule

// File: rtl/cam_readout_sched.sv
// Camera line-buffer readout scheduler: counts half-line-ready pulses and
// issues HALF_LEN-byte read bursts along a ring pointer, streaming the bytes
// out with frame/line markers through a 2-entry skid FIFO.
//   pclk, rst_n  : clock, async active-low reset
//   arm          : pulse, capture next frame (IDLE only)
//   continuous   : re-arm automatically after each frame
//   frame_irq    : vsync level (high = blanking)
//   half_irq     : pulse, one half-line written to RAM
//   clr_overrun  : clears the sticky overrun flag
//   bus          : RAM read port + output byte stream (master side)
//   busy         : sequencer not IDLE
//   overrun      : sticky, half_irq seen with two halves already pending
//   line_count   : lines completed in the current frame (saturating)
module cam_readout_sched
  import cam_pkg::*;
#(
  parameter int unsigned ADDR_W   = CAM_ADDR_W,
  parameter int unsigned HALF_LEN = CAM_HALF_LEN,
  parameter int unsigned LINE_W   = CAM_LINE_W
)(
  input  logic                 pclk,
  input  logic                 rst_n,
  input  logic                 arm,
  input  logic                 continuous,
  input  logic                 frame_irq,
  input  logic                 half_irq,
  input  logic                 clr_overrun,
  cam_readout_sched_if.master  bus,
  output logic                 busy,
  output logic                 overrun,
  output logic [LINE_W-1:0]    line_count
);

  localparam int unsigned       CNT_W    = (HALF_LEN > 1) ? $clog2(HALF_LEN) : 1;
  localparam logic [CNT_W-1:0]  LAST     = CNT_W'(HALF_LEN - 1);
  localparam logic [LINE_W-1:0] LINE_MAX = '1;

  cam_state_e        state;
  logic              vs_q;
  logic              vs_d;
  logic [1:0]        pending;
  logic [CNT_W-1:0]  burst_cnt;
  logic [ADDR_W-1:0] ptr;
  logic              half_idx;
  logic              sof_pend;
  logic              rd_vld_q;
  logic              rd_sof_q;
  logic              rd_eol_q;

  cam_beat_t         fifo_din;
  cam_beat_t         fifo_head;
  logic              fifo_vld;
  logic [1:0]        fifo_cnt;

  logic vs_rise_c;
  logic vs_fall_c;
  logic pop_c;
  logic space_c;
  logic rd_go_c;
  logic last_c;
  logic half_ok_c;
  logic inc_c;
  logic ovf_c;
  logic enter_act_c;
  logic drained_c;

  assign vs_rise_c   = vs_q & ~vs_d;
  assign vs_fall_c   = ~vs_q & vs_d;
  assign pop_c       = fifo_vld & bus.out_ready;
  // Occupancy plus the read returning this cycle, less the byte leaving now,
  // must leave room for one more; crediting the pop keeps 1 byte/cycle.
  assign space_c     = (3'(fifo_cnt) + 3'(rd_vld_q)) < (3'd2 + 3'(pop_c));
  // pending counts halves not fully read, so it is nonzero only in ACTIVE/FLUSH.
  assign rd_go_c     = space_c && (pending != 2'd0);
  assign last_c      = rd_go_c && (burst_cnt == LAST);
  assign half_ok_c   = half_irq && (state == ACTIVE);
  assign ovf_c       = half_ok_c && (pending == 2'd2);
  assign inc_c       = half_ok_c && (pending != 2'd2);
  assign enter_act_c = (state == WAIT_VS) && vs_fall_c;
  assign drained_c   = (pending == 2'd0) && (fifo_cnt == 2'd0) && !rd_vld_q;

  assign fifo_din      = '{eol: rd_eol_q, sof: rd_sof_q, data: bus.rd_data};
  assign bus.rd_en     = rd_go_c;
  assign bus.rd_addr   = ptr;
  assign bus.out_data  = fifo_head.data;
  assign bus.out_sof   = fifo_head.sof;
  assign bus.out_eol   = fifo_head.eol;
  assign bus.out_valid = fifo_vld;

  // Frame sequencer.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (arm) begin
          state <= WAIT_VS;
          busy  <= 1'b1;
        end
        WAIT_VS: if (vs_fall_c) state <= ACTIVE;
        ACTIVE:  if (vs_rise_c) state <= FLUSH;
        FLUSH: if (drained_c) begin
          if (continuous) begin
            state <= WAIT_VS;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Vsync sampling, pending halves, burst walk, markers and status.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q       <= 1'b0;
      vs_d       <= 1'b0;
      pending    <= '0;
      burst_cnt  <= '0;
      ptr        <= '0;
      half_idx   <= 1'b0;
      sof_pend   <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_sof_q   <= 1'b0;
      rd_eol_q   <= 1'b0;
      overrun    <= 1'b0;
      line_count <= '0;
    end else begin
      vs_q <= frame_irq;
      vs_d <= vs_q;

      unique case ({inc_c, last_c})
        2'b10:   pending <= pending + 2'd1;
        2'b01:   pending <= pending - 2'd1;
        default: ;
      endcase

      if (rd_go_c) burst_cnt <= last_c ? '0 : burst_cnt + CNT_W'(1);

      if (enter_act_c) begin
        ptr      <= '0;
        half_idx <= 1'b0;
        sof_pend <= 1'b1;
      end else begin
        if (rd_go_c) begin
          ptr      <= ptr + ADDR_W'(1);
          sof_pend <= 1'b0;
        end
        if (last_c) half_idx <= ~half_idx;
      end

      // Markers travel alongside the read through the RAM latency.
      rd_vld_q <= rd_go_c;
      rd_sof_q <= rd_go_c & sof_pend;
      rd_eol_q <= last_c & half_idx;

      // A new overrun wins over a same-cycle clear.
      if (ovf_c)            overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;

      if (enter_act_c)
        line_count <= '0;
      else if (pop_c && fifo_head.eol && (line_count != LINE_MAX))
        line_count <= line_count + LINE_W'(1);
    end
  end

  cam_skid_fifo u_fifo (
    .pclk     (pclk),
    .rst_n    (rst_n),
    .push     (rd_vld_q),
    .din      (fifo_din),
    .pop      (pop_c),
    .head     (fifo_head),
    .head_vld (fifo_vld),
    .count    (fifo_cnt)
  );

endmodule

// File: tb/tb_cam_readout_sched.sv
// Scoreboard bench for cam_readout_sched: stimulus pushes expected read
// addresses and stream beats into queues; a negedge monitor pops and compares.
module tb_cam_readout_sched;
  import cam_pkg::*;

  localparam int unsigned AW = 11;
  localparam int unsigned HL = 780;
  localparam int unsigned LW = 10;

  logic          pclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0;
  logic          continuous = 1'b0;
  logic          frame_irq = 1'b1;
  logic          half_irq = 1'b0;
  logic          clr_overrun = 1'b0;
  logic          busy;
  logic          overrun;
  logic [LW-1:0] line_count;

  logic rdy_level = 1'b1;
  logic rand_rdy = 1'b0;

  int tests = 0;
  int fails = 0;
  int issued = 0;
  int accepted = 0;

  logic [AW-1:0] addr_q[$];
  cam_beat_t     beat_q[$];

  logic [AW-1:0] e_ptr;
  logic          e_half;
  logic          e_sof;

  logic [AW-1:0] m_addr;
  cam_beat_t     m_exp;
  cam_beat_t     m_act;

  cam_readout_sched_if #(.ADDR_W(AW)) bus();

  cam_readout_sched #(.ADDR_W(AW), .HALF_LEN(HL), .LINE_W(LW)) dut (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .arm         (arm),
    .continuous  (continuous),
    .frame_irq   (frame_irq),
    .half_irq    (half_irq),
    .clr_overrun (clr_overrun),
    .bus         (bus),
    .busy        (busy),
    .overrun     (overrun),
    .line_count  (line_count)
  );

  always #5 pclk = ~pclk;

  function automatic logic [7:0] ram_f(input logic [AW-1:0] a);
    return 8'(a[7:0] + 8'(a[10:8]) * 8'd37 + 8'd5);
  endfunction

  // RAM model, 1-cycle read latency.
  always @(posedge pclk) if (bus.rd_en === 1'b1) bus.rd_data <= ram_f(bus.rd_addr);

  // Consumer ready: fixed level or ~30% random.
  always @(posedge pclk) begin
    #1;
    if (rand_rdy) bus.out_ready = ($urandom_range(0, 9) < 3);
    else          bus.out_ready = rdy_level;
  end

  // Monitor: read addresses, stream beats, and outstanding-read bound.
  always @(negedge pclk) begin
    if (rst_n === 1'b1) begin
      if (bus.rd_en === 1'b1) begin
        issued++;
        tests++;
        if (addr_q.size() == 0) begin
          fails++;
          $display("FAIL rd_addr: unexpected read at addr %0d", bus.rd_addr);
        end else begin
          m_addr = addr_q.pop_front();
          if (bus.rd_addr !== m_addr) begin
            fails++;
            $display("FAIL rd_addr: got %0d expected %0d", bus.rd_addr, m_addr);
          end
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        accepted++;
        tests++;
        m_act = '{eol: bus.out_eol, sof: bus.out_sof, data: bus.out_data};
        if (beat_q.size() == 0) begin
          fails++;
          $display("FAIL beat: unexpected beat %h", m_act);
        end else begin
          m_exp = beat_q.pop_front();
          if (m_act !== m_exp) begin
            fails++;
            $display("FAIL beat: got {eol,sof,data}=%h expected %h", m_act, m_exp);
          end
        end
      end
      if (bus.rd_en === 1'b1) begin
        tests++;
        if (issued - accepted > 2) begin
          fails++;
          $display("FAIL credit: outstanding %0d expected <= 2", issued - accepted);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_half();
    logic [AW-1:0] a;
    for (int i = 0; i < int'(HL); i++) begin
      a = e_ptr + AW'(i);
      addr_q.push_back(a);
      beat_q.push_back('{eol: e_half && (i == int'(HL) - 1), sof: e_sof && (i == 0), data: ram_f(a)});
    end
    e_ptr  = e_ptr + AW'(HL);
    e_half = ~e_half;
    e_sof  = 1'b0;
  endtask

  task automatic half_pulse(input bit expect_burst);
    if (expect_burst) push_half();
    half_irq = 1'b1;
    tick(1);
    half_irq = 1'b0;
  endtask

  task automatic open_frame(input bit do_arm);
    if (do_arm) begin
      arm = 1'b1;
      tick(1);
      arm = 1'b0;
    end
    tick(2);
    frame_irq = 1'b0;
    e_ptr  = '0;
    e_half = 1'b0;
    e_sof  = 1'b1;
    tick(4);
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int n;
    n = 0;
    while ((addr_q.size() != 0 || beat_q.size() != 0) && n < budget) begin
      tick(1);
      n++;
    end
    tests++;
    if (addr_q.size() != 0 || beat_q.size() != 0) begin
      fails++;
      $display("FAIL %s: timeout with %0d reads and %0d beats outstanding",
               nm, addr_q.size(), beat_q.size());
      addr_q.delete();
      beat_q.delete();
    end
  endtask

  initial begin
    int iss0;
    tick(3);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_line_count", int'(line_count), 0);
    chk("rst_rd_en", int'(bus.rd_en), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    rst_n = 1'b1;
    tick(3);

    // One line at full rate, then a second line crossing the pointer wrap.
    open_frame(1'b1);
    half_pulse(1'b1);
    tick(20);
    half_pulse(1'b1);
    wait_drain("t1_drain", 5000);
    tick(4);
    chk("t1_line_count", int'(line_count), 1);
    chk("t1_busy", int'(busy), 1);
    half_pulse(1'b1);
    half_pulse(1'b1);
    wait_drain("t2_drain", 5000);
    tick(4);
    chk("t2_line_count", int'(line_count), 2);
    frame_irq = 1'b1;
    tick(8);
    chk("t2_idle", int'(busy), 0);

    // Random backpressure.
    rand_rdy = 1'b1;
    open_frame(1'b1);
    half_pulse(1'b1);
    half_pulse(1'b1);
    wait_drain("t3_drain", 20000);
    rand_rdy = 1'b0;
    tick(4);
    chk("t3_line_count", int'(line_count), 1);
    frame_irq = 1'b1;
    tick(8);
    chk("t3_idle", int'(busy), 0);

    // Overrun with the consumer stalled.
    rdy_level = 1'b0;
    tick(2);
    open_frame(1'b1);
    half_pulse(1'b1);
    half_pulse(1'b1);
    half_pulse(1'b0);
    tick(4);
    chk("t4_overrun_set", int'(overrun), 1);
    chk("t4_stalled_valid", int'(bus.out_valid), 1);
    rdy_level = 1'b1;
    wait_drain("t4_drain", 5000);
    tick(4);
    chk("t4_line_count", int'(line_count), 1);
    chk("t4_overrun_sticky", int'(overrun), 1);
    clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0;
    tick(1);
    chk("t4_overrun_clr", int'(overrun), 0);
    frame_irq = 1'b1;
    tick(8);
    chk("t4_idle", int'(busy), 0);

    // Vsync rise mid-burst, single-shot: drain then IDLE.
    open_frame(1'b1);
    half_pulse(1'b1);
    tick(100);
    frame_irq = 1'b1;
    tick(5);
    half_pulse(1'b0);
    wait_drain("t5a_drain", 5000);
    tick(6);
    chk("t5a_idle", int'(busy), 0);
    chk("t5a_no_overrun", int'(overrun), 0);
    chk("t5a_line_count", int'(line_count), 0);

    // Vsync rise mid-burst, continuous: drain then wait for next frame.
    continuous = 1'b1;
    open_frame(1'b1);
    half_pulse(1'b1);
    tick(100);
    frame_irq = 1'b1;
    tick(5);
    half_pulse(1'b0);
    wait_drain("t5b_drain", 5000);
    tick(6);
    chk("t5b_rearmed", int'(busy), 1);
    open_frame(1'b0);
    half_pulse(1'b1);
    half_pulse(1'b1);
    wait_drain("t5b_next_drain", 5000);
    tick(4);
    chk("t5b_line_count", int'(line_count), 1);
    continuous = 1'b0;
    frame_irq = 1'b1;
    tick(8);
    chk("t5b_idle", int'(busy), 0);

    // Reset mid-burst.
    open_frame(1'b1);
    half_pulse(1'b1);
    tick(50);
    #2;
    rst_n = 1'b0;
    addr_q.delete();
    beat_q.delete();
    issued = 0;
    accepted = 0;
    #1;
    chk("t6_rst_rd_en", int'(bus.rd_en), 0);
    chk("t6_rst_rd_addr", int'(bus.rd_addr), 0);
    chk("t6_rst_valid", int'(bus.out_valid), 0);
    chk("t6_rst_data", int'(bus.out_data), 0);
    chk("t6_rst_sof", int'(bus.out_sof), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_line_count", int'(line_count), 0);
    tick(2);
    rst_n = 1'b1;
    frame_irq = 1'b1;
    tick(3);

    // arm while ACTIVE must not send the sequencer back to WAIT_VS.
    open_frame(1'b1);
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    tick(2);
    frame_irq = 1'b1;
    tick(8);
    chk("t6_arm_ignored", int'(busy), 0);

    // Vsync fall without arm: no reads.
    iss0 = issued;
    frame_irq = 1'b0;
    tick(4);
    half_pulse(1'b0);
    tick(20);
    chk("t6_no_reads", issued - iss0, 0);
    chk("t6_still_idle", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
